accel_sample_sched: RTL and testbench

Sequencer that sits between the accelerometer read interface and the X/Y moving-average filters. At a fixed sample rate it reads the X axis, then the Y axis, over one shared req/ack read port. It then commits both samples to the filters together, with a single history-shift pulse. It also owns the filter-mode setting, applying user changes only on sample boundaries and gating output validity until the filter history is refilled.

---
 rtl/accel_sample_sched_if.sv | 11 +
 rtl/accel_sample_sched.sv | 168 ++++++++++++++++
 tb/tb_accel_sample_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_sample_sched_if.sv
// Shared accelerometer read port: one request at a time, axis-tagged,
// completed by a single-cycle ack that carries the data.
interface accel_sample_sched_if;
  logic        rd_req;
  logic        rd_axis;
  logic        rd_ack;
  logic [15:0] rd_data;

  modport master (output rd_req, rd_axis, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_axis, output rd_ack, rd_data);
endinterface

// File: rtl/accel_sample_sched.sv
// Sample sequencer: on each sample tick reads X then Y over the shared read
// port, commits both to the filters with one shift pulse, and applies filter
// mode changes only at commit while tracking history refill for valid.
module accel_sample_sched #(
  parameter int DIV     = 250000,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [1:0]                  filter_sel,
  input  logic                        clear_err,
  accel_sample_sched_if.master        rd,
  output logic [15:0]                 x_sample,
  output logic [15:0]                 y_sample,
  output logic                        shift_en,
  output logic [1:0]                  filter_mode,
  output logic                        valid,
  output logic                        timeout_err,
  output logic                        overrun_err
);
  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_REQX   = 3'd2;
  localparam logic [2:0] S_REQY   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    sel_s1, sel_s2;
  logic [15:0]   x_hold, y_hold;
  logic [3:0]    flush_cnt;
  logic          fresh;
  logic          tick, acked, expired, rd_done, commit;

  // last history index for a mode: taps-1 (1, 2, 4, 16 taps)
  function automatic logic [3:0] tap_last(input logic [1:0] m);
    case (m)
      2'b00:   tap_last = 4'd0;
      2'b01:   tap_last = 4'd1;
      2'b10:   tap_last = 4'd3;
      default: tap_last = 4'd15;
    endcase
  endfunction

  assign tick    = enable && (tick_cnt == CW'(DIV - 1));
  // ack only counts against an outstanding request
  assign acked   = rd.rd_req && rd.rd_ack;
  assign expired = rd.rd_req && !rd.rd_ack && (to_cnt == TW'(TIMEOUT - 1));
  assign rd_done = acked || expired;
  assign commit  = (state == S_REQY) && rd_done;

  // sample-rate divider, parked at 0 while sampling is disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      tick_cnt <= '0;
    else if (!enable)                  tick_cnt <= '0;
    else if (tick_cnt == CW'(DIV - 1)) tick_cnt <= '0;
    else                               tick_cnt <= tick_cnt + 1'b1;
  end

  // two-flop synchroniser for the switch inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_s1 <= 2'b00;
      sel_s2 <= 2'b00;
    end else begin
      sel_s1 <= filter_sel;
      sel_s2 <= sel_s1;
    end
  end

  // sequencer and read handshake; X request issues with the tick, Y request
  // one cycle after REQ_Y entry so rd_req visibly drops between axes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rd.rd_req  <= 1'b0;
      rd.rd_axis <= 1'b0;
      to_cnt  <= '0;
      x_hold  <= '0;
      y_hold  <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) state <= S_WAIT;
        S_WAIT: begin
          if (!enable) state <= S_IDLE;
          else if (tick) begin
            state      <= S_REQX;
            rd.rd_req  <= 1'b1;
            rd.rd_axis <= 1'b0;
            to_cnt     <= '0;
          end
        end
        S_REQX: begin
          if (rd_done) begin
            rd.rd_req <= 1'b0;
            to_cnt    <= '0;
            state     <= S_REQY;
            if (acked) x_hold <= rd.rd_data;
          end else if (rd.rd_req) to_cnt <= to_cnt + 1'b1;
        end
        S_REQY: begin
          if (!rd.rd_req) begin
            rd.rd_req  <= 1'b1;
            rd.rd_axis <= 1'b1;
          end else if (rd_done) begin
            rd.rd_req <= 1'b0;
            state     <= S_COMMIT;
            if (acked) y_hold <= rd.rd_data;
          end else to_cnt <= to_cnt + 1'b1;
        end
        S_COMMIT: state <= enable ? S_WAIT : S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // commit: samples, mode and refill tracking all change together with shift_en
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_en    <= 1'b0;
      x_sample    <= '0;
      y_sample    <= '0;
      filter_mode <= 2'b00;
      flush_cnt   <= 4'd15;
      fresh       <= 1'b1;
      valid       <= 1'b0;
    end else begin
      shift_en <= commit;
      if (commit) begin
        x_sample    <= x_hold;
        y_sample    <= acked ? rd.rd_data : y_hold;
        filter_mode <= sel_s2;
        if (fresh) begin
          // empty history after reset: this commit is only the first of 16
          fresh     <= 1'b0;
          flush_cnt <= 4'd15;
          valid     <= 1'b0;
        end else if (sel_s2 != filter_mode) begin
          flush_cnt <= tap_last(sel_s2);
          valid     <= (sel_s2 == 2'b00);
        end else if (flush_cnt != 4'd0) begin
          flush_cnt <= flush_cnt - 1'b1;
          valid     <= (flush_cnt == 4'd1);
        end else begin
          valid     <= 1'b1;
        end
      end
    end
  end

  // sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (expired)        timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (tick && state != S_WAIT) overrun_err <= 1'b1;
      else if (clear_err)          overrun_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accel_sample_sched.sv
// Randomised bench: responder drives the read port with random data, and a
// commit-level model predicts samples, mode and valid from first principles.
module tb_accel_sample_sched;
  logic        clock, reset_n, enable, clear_err;
  logic [1:0]  filter_sel;
  logic [15:0] x_sample, y_sample;
  logic        shift_en, valid, timeout_err, overrun_err;
  logic [1:0]  filter_mode;

  accel_sample_sched_if rd_if();

  accel_sample_sched #(.DIV(16), .TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .filter_sel(filter_sel),
    .clear_err(clear_err), .rd(rd_if), .x_sample(x_sample), .y_sample(y_sample),
    .shift_en(shift_en), .filter_mode(filter_mode), .valid(valid),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  int n_chk = 0, n_fail = 0;
  int ncommit = 0, cyc = 0, last_commit = 0, gap = 0, bad_stable = 0;
  int age = 0, ack_dly = 2, hi_run = 0;
  int run_len [2];
  logic ack_en_x = 1'b1, stray_go = 1'b0;
  logic exp_axis = 1'b0, prev_req = 1'b0, cur_axis = 1'b0;
  logic [15:0] exp_x = '0, exp_y = '0, prev_x = '0, prev_y = '0, d;
  logic [1:0]  m_mode = 2'b00, prev_mode = 2'b00;
  int m_need = 16, m_cnt = 0;
  bit m_fresh = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int taps(input logic [1:0] s);
    return 1 << ((s == 2'b11) ? 4 : int'(s));
  endfunction

  task automatic model_reset();
    m_fresh = 1'b1; m_mode = 2'b00; m_cnt = 0; m_need = 16;
    exp_x = '0; exp_y = '0;
  endtask

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic wait_commits(input int n);
    int tgt, b;
    tgt = ncommit + n; b = 0;
    while (ncommit < tgt && b < 64 * n + 64) begin step(); b++; end
    if (ncommit < tgt) chk("wait_commit", 32'(ncommit), 32'(tgt));
  endtask

  // read-port responder: ack after ack_dly request cycles with random data
  initial begin
    rd_if.rd_ack = 1'b0; rd_if.rd_data = '0;
    forever begin
      @(posedge clock); #1;
      rd_if.rd_ack = 1'b0;
      if (rd_if.rd_req) age++; else age = 0;
      if (rd_if.rd_req && age == ack_dly && (rd_if.rd_axis || ack_en_x)) begin
        d = 16'($urandom);
        rd_if.rd_ack = 1'b1; rd_if.rd_data = d;
        if (rd_if.rd_axis) exp_y = d; else exp_x = d;
      end else if (!rd_if.rd_req && stray_go) begin
        stray_go = 1'b0;
        rd_if.rd_ack = 1'b1; rd_if.rd_data = 16'hdead;
      end
    end
  end

  // monitor: axis order, request run lengths, commit model, output stability
  initial begin
    run_len[0] = 0; run_len[1] = 0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      if (!reset_n) begin
        exp_axis = 1'b0; hi_run = 0; prev_req = 1'b0;
      end else begin
        if (rd_if.rd_req && !prev_req) begin
          chk("axis_order", 32'(rd_if.rd_axis), 32'(exp_axis));
          exp_axis = ~exp_axis;
        end
        if (rd_if.rd_req) begin hi_run++; cur_axis = rd_if.rd_axis; end
        else if (hi_run > 0) begin run_len[cur_axis] = hi_run; hi_run = 0; end
        if (shift_en) begin
          if (m_fresh) begin m_fresh = 1'b0; m_need = 16; m_cnt = 1; end
          else if (filter_sel != m_mode) begin m_need = taps(filter_sel); m_cnt = 1; end
          else m_cnt++;
          m_mode = filter_sel;
          chk("x_sample", 32'(x_sample), 32'(exp_x));
          chk("y_sample", 32'(y_sample), 32'(exp_y));
          chk("filter_mode", 32'(filter_mode), 32'(m_mode));
          chk("valid", 32'(valid), 32'(m_cnt >= m_need));
          gap = cyc - last_commit; last_commit = cyc;
          ncommit++;
          exp_axis = 1'b0;
        end else if (filter_mode != prev_mode || x_sample != prev_x || y_sample != prev_y)
          bad_stable++;
        prev_req = rd_if.rd_req;
      end
      prev_mode = filter_mode; prev_x = x_sample; prev_y = y_sample;
    end
  end

  initial begin
    int n, rises;
    logic pr;
    reset_n = 1'b0; enable = 1'b0; filter_sel = 2'b00; clear_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    chk("rst_rd_req", 32'(rd_if.rd_req), 0);
    chk("rst_shift_en", 32'(shift_en), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_mode", 32'(filter_mode), 0);
    chk("rst_errs", 32'({timeout_err, overrun_err}), 0);
    chk("rst_samples", 32'({x_sample, y_sample}), 0);
    reset_n = 1'b1;
    step();
    enable = 1'b1;

    // steady sampling, valid first at 16th commit
    wait_commits(20);
    chk("period", 32'(gap), 16);
    chk("valid_steady", 32'(valid), 1);

    // mode changes applied only at commit
    filter_sel = 2'b10;
    wait_commits(6);
    for (int i = 0; i < 6; i++) begin
      filter_sel = 2'($urandom);
      wait_commits(1 + $urandom_range(0, 4));
    end
    filter_sel = 2'b01;
    wait_commits(3);

    // ack with no request outstanding must be ignored
    stray_go = 1'b1;
    wait_commits(2);

    // X read timeout
    ack_en_x = 1'b0;
    wait_commits(1);
    ack_en_x = 1'b1;
    chk("to_run_len", 32'(run_len[0]), 8);
    chk("to_err_set", 32'(timeout_err), 1);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 0);

    // slow device: sequence outlasts the sample period
    ack_dly = 20;
    wait_commits(2);
    chk("ovr_err_set", 32'(overrun_err), 1);
    ack_dly = 2;
    wait_commits(2);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("ovr_err_clr", 32'(overrun_err), 0);
    chk("to_err_clr2", 32'(timeout_err), 0);

    // drop enable during the Y read
    n = 0;
    while (!(rd_if.rd_req && rd_if.rd_axis) && n < 200) begin step(); n++; end
    if (n >= 200) chk("wait_req_y", 0, 1);
    enable = 1'b0;
    wait_commits(1);
    rises = 0; pr = rd_if.rd_req;
    repeat (40) begin
      step();
      if (rd_if.rd_req && !pr) rises++;
      pr = rd_if.rd_req;
    end
    chk("idle_no_req", 32'(rises), 0);
    enable = 1'b1;
    n = 0;
    while (!rd_if.rd_req && n < 100) begin step(); n++; end
    chk("reenable_lat", 32'(n), 16);

    // reset in the middle of a handshake
    wait_commits(1);
    ack_en_x = 1'b0;
    wait_commits(1);
    ack_en_x = 1'b1;
    chk("pre_rst_to", 32'(timeout_err), 1);
    chk("pre_rst_valid", 32'(valid), 1);
    n = 0;
    while (!rd_if.rd_req && n < 100) begin step(); n++; end
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_req", 32'(rd_if.rd_req), 0);
    chk("mid_rst_shift_en", 32'(shift_en), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_errs", 32'({timeout_err, overrun_err}), 0);
    chk("mid_rst_mode", 32'(filter_mode), 0);
    model_reset();
    filter_sel = 2'b11;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // refill after reset is 16 commits regardless of mode
    wait_commits(18);
    chk("final_valid", 32'(valid), 1);
    chk("stable_off_commit", 32'(bad_stable), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
